// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, control key
// codes, coin values and the keypad validity helper.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    QTY,
    PAY,
    VEND
  } state_t;

  localparam logic [3:0] KEY_START   = 4'd15;
  localparam logic [3:0] KEY_CONFIRM = 4'd14;
  localparam logic [3:0] KEY_CANCEL  = 4'd13;

  // Coin keys 0..3 are worth 1, 2, 5 and 10; key 0 in the LSBs.
  localparam logic [15:0] COIN_TABLE = {4'd10, 4'd5, 4'd2, 4'd1};

  function automatic logic one_hot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Exactly one column and exactly one row pulled low.
  function automatic logic key_valid(input logic [3:0] c, input logic [3:0] r);
    return one_hot4(~c) && one_hot4(~r);
  endfunction

  function automatic logic [3:0] coin_value(input logic [1:0] k);
    return COIN_TABLE[{k, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Samples the active-low 4x4 keypad once and turns a released-to-valid-key
// transition into a single press event carrying the key index.
module keypad_decoder
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] c,
  input  logic [3:0] r,
  output logic       press,
  output logic [3:0] key
);

  logic [3:0] c_p0;
  logic [3:0] r_p0;
  logic       armed;
  logic [1:0] row;
  logic [1:0] col;

  // Stage p0: registered keypad sample and press arming
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_p0  <= 4'hF;
      r_p0  <= 4'hF;
      armed <= 1'b1;
    end else begin
      c_p0 <= c;
      r_p0 <= r;
      if (c_p0 == 4'hF && r_p0 == 4'hF)
        armed <= 1'b1;
      else if (press)
        armed <= 1'b0;
    end
  end

  always_comb begin
    row = 2'd0;
    col = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!r_p0[i]) row = 2'(i);
      if (!c_p0[i]) col = 2'(i);
    end
  end

  assign press = armed && key_valid(c_p0, r_p0);
  assign key   = {row, col};

endmodule

// File: rtl/vend_controller.sv
// Vending controller top: purchase FSM, money datapath, per-product stock and
// inactivity timeout, driven by press events from the keypad decoder.
module vend_controller
  import vend_pkg::*;
#(
  parameter int                              NUM_PRODUCTS   = 4,
  parameter int                              PRICE_W        = 8,
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES         = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                              MAX_QTY        = 4,
  parameter int                              INIT_STOCK     = 3,
  parameter int                              TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         c,
  input  logic [3:0]         r,
  output logic [PRICE_W-1:0] view_price,
  output logic [7:0]         view_quantity,
  output logic [PRICE_W-1:0] view_price_q,
  output logic [PRICE_W-1:0] entered_amount,
  output logic [PRICE_W-1:0] change_amount,
  output logic               vend_valid,
  output logic [3:0]         vend_product,
  output logic [7:0]         vend_qty,
  output logic               error
);

  localparam int STOCK_W = 8;
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  logic                 press;
  logic [3:0]           key;
  state_t               state, state_nxt;
  logic [3:0]           sel, sel_nxt;
  logic [PRICE_W-1:0]   price_nxt, total_nxt, entered_nxt, change_nxt;
  logic [7:0]           qty_nxt;
  logic                 vend_nxt, error_nxt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 active, timeout;
  logic                 key_is_prod;
  logic [PRICE_W-1:0]   price_key;
  logic [STOCK_W-1:0]   stock_key, stock_sel;
  logic [PRICE_W+3:0]   qty_total;
  logic [PRICE_W:0]     coin_sum;
  logic                 qty_ok;
  logic [PRICE_W-1:0]   price_tab [NUM_PRODUCTS];
  logic [STOCK_W-1:0]   stock     [NUM_PRODUCTS];

  keypad_decoder u_keypad (
    .clk   (clk),
    .reset (reset),
    .c     (c),
    .r     (r),
    .press (press),
    .key   (key)
  );

  for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_price
    assign price_tab[g] = PRICES[g*PRICE_W +: PRICE_W];
  end

  always_comb begin
    key_is_prod = 1'b0;
    price_key   = '0;
    stock_key   = '0;
    stock_sel   = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (key == 4'(i)) begin
        key_is_prod = 1'b1;
        price_key   = price_tab[i];
        stock_key   = stock[i];
      end
      if (sel == 4'(i)) stock_sel = stock[i];
    end
  end

  assign qty_total = {4'b0, view_price} * {{PRICE_W{1'b0}}, key};
  assign coin_sum  = {1'b0, entered_amount} + {{(PRICE_W-3){1'b0}}, coin_value(key[1:0])};
  assign qty_ok    = (key >= 4'd1) && (key <= 4'(MAX_QTY)) &&
                     ({4'b0, key} <= stock_sel) && (qty_total[PRICE_W+3:PRICE_W] == 4'd0);
  assign active    = (state == SELECT) || (state == QTY) || (state == PAY);
  assign timeout   = active && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    price_nxt   = view_price;
    qty_nxt     = view_quantity;
    total_nxt   = view_price_q;
    entered_nxt = entered_amount;
    change_nxt  = change_amount;
    vend_nxt    = 1'b0;
    error_nxt   = 1'b0;
    // Timeout takes priority over any press decoded on the same edge.
    if (timeout || (press && active && key == KEY_CANCEL)) begin
      change_nxt  = entered_amount;
      price_nxt   = '0;
      qty_nxt     = '0;
      total_nxt   = '0;
      entered_nxt = '0;
      state_nxt   = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (press && key == KEY_START) begin
            price_nxt   = '0;
            qty_nxt     = '0;
            total_nxt   = '0;
            entered_nxt = '0;
            state_nxt   = SELECT;
          end
        end
        SELECT: begin
          if (press) begin
            if (key_is_prod && stock_key != '0) begin
              sel_nxt   = key;
              price_nxt = price_key;
              state_nxt = QTY;
            end else begin
              error_nxt = 1'b1;
            end
          end
        end
        QTY: begin
          if (press) begin
            if (key == KEY_CONFIRM) begin
              if (view_quantity != 8'd0) state_nxt = PAY;
              else                       error_nxt = 1'b1;
            end else if (qty_ok) begin
              qty_nxt   = {4'b0, key};
              total_nxt = qty_total[PRICE_W-1:0];
            end else begin
              error_nxt = 1'b1;
            end
          end
        end
        PAY: begin
          if (press) begin
            if (key[3:2] == 2'b00 && !coin_sum[PRICE_W]) begin
              entered_nxt = coin_sum[PRICE_W-1:0];
              if (coin_sum[PRICE_W-1:0] >= view_price_q) state_nxt = VEND;
            end else begin
              error_nxt = 1'b1;
            end
          end
        end
        VEND: begin
          vend_nxt   = 1'b1;
          change_nxt = entered_amount - view_price_q;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      sel            <= '0;
      view_price     <= '0;
      view_quantity  <= '0;
      view_price_q   <= '0;
      entered_amount <= '0;
      change_amount  <= '0;
      vend_valid     <= 1'b0;
      vend_product   <= '0;
      vend_qty       <= '0;
      error          <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      state          <= state_nxt;
      sel            <= sel_nxt;
      view_price     <= price_nxt;
      view_quantity  <= qty_nxt;
      view_price_q   <= total_nxt;
      entered_amount <= entered_nxt;
      change_amount  <= change_nxt;
      vend_valid     <= vend_nxt;
      error          <= error_nxt;
      if (vend_nxt) begin
        vend_product <= sel;
        vend_qty     <= view_quantity;
      end
      if (!active || press || timeout) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (!reset)
        stock[i] <= STOCK_W'(INIT_STOCK);
      else if (vend_nxt && sel == 4'(i))
        stock[i] <= stock[i] - view_quantity;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Table-driven bench for vend_controller with a scoreboard of expected vends and
// hand-written sequences for timeout, held keys, multi-key patterns and reset.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] c, r;
  logic [7:0] view_price, view_quantity, view_price_q, entered_amount, change_amount, vend_qty;
  logic       vend_valid, error;
  logic [3:0] vend_product;

  vend_controller #(.TIMEOUT_CYCLES(50)) dut (
    .clk            (clk),
    .reset          (reset),
    .c              (c),
    .r              (r),
    .view_price     (view_price),
    .view_quantity  (view_quantity),
    .view_price_q   (view_price_q),
    .entered_amount (entered_amount),
    .change_amount  (change_amount),
    .vend_valid     (vend_valid),
    .vend_product   (vend_product),
    .vend_qty       (vend_qty),
    .error          (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic [7:0] price, qty, total, entered, change;
    int         err;
    bit         vend;
    logic [3:0] vp;
    logic [7:0] vq, vchg;
  } step_t;

  typedef struct {
    logic [3:0] p;
    logic [7:0] q, chg;
  } vend_t;

  step_t steps[$];
  vend_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    err_seen = 0;
  logic  prev_err = 1'b0;
  logic  prev_vend = 1'b0;

  localparam logic [3:0] S = 4'd15, K = 4'd14, X = 4'd13;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic step_t mk(input logic [3:0] key, input int price, input int qty,
                               input int total, input int entered, input int change,
                               input int err, input bit vend = 1'b0, input int vp = 0,
                               input int vq = 0, input int vchg = 0);
    step_t s;
    s.key = key;        s.price = 8'(price);  s.qty = 8'(qty);
    s.total = 8'(total); s.entered = 8'(entered); s.change = 8'(change);
    s.err = err;        s.vend = vend;        s.vp = 4'(vp);
    s.vq = 8'(vq);      s.vchg = 8'(vchg);
    return s;
  endfunction

  // Scoreboard and pulse-width monitor
  always @(negedge clk) begin
    if (error) begin
      err_seen++;
      check("error_width", {31'b0, prev_err}, 0);
    end
    if (vend_valid) begin
      check("vend_width", {31'b0, prev_vend}, 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_vend: got product %0d qty %0d, expected no vend", vend_product, vend_qty);
      end else begin
        vend_t v;
        v = sb.pop_front();
        check("vend_product", vend_product, v.p);
        check("vend_qty", vend_qty, v.q);
        check("vend_change", change_amount, v.chg);
      end
    end
    prev_err  = error;
    prev_vend = vend_valid;
  end

  task automatic drive_key(input logic [3:0] k);
    c = ~(4'b0001 << k[1:0]);
    r = ~(4'b0001 << k[3:2]);
  endtask

  task automatic release_keys();
    c = 4'hF;
    r = 4'hF;
  endtask

  task automatic press_key(input logic [3:0] k);
    @(posedge clk); #1 drive_key(k);
    repeat (2) @(posedge clk);
    #1 release_keys();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " view_price"}, view_price, 0);
    check({tag, " view_quantity"}, view_quantity, 0);
    check({tag, " view_price_q"}, view_price_q, 0);
    check({tag, " entered"}, entered_amount, 0);
    check({tag, " change"}, change_amount, 0);
    check({tag, " vend_valid"}, {31'b0, vend_valid}, 0);
    check({tag, " vend_product"}, vend_product, 0);
    check({tag, " vend_qty"}, vend_qty, 0);
    check({tag, " error"}, {31'b0, error}, 0);
  endtask

  task automatic run_steps(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step_t s;
      int    e0;
      s  = steps[i];
      e0 = err_seen;
      if (s.vend) begin
        vend_t v;
        v.p = s.vp; v.q = s.vq; v.chg = s.vchg;
        sb.push_back(v);
      end
      press_key(s.key);
      check($sformatf("step%0d view_price", i), view_price, s.price);
      check($sformatf("step%0d view_quantity", i), view_quantity, s.qty);
      check($sformatf("step%0d view_price_q", i), view_price_q, s.total);
      check($sformatf("step%0d entered", i), entered_amount, s.entered);
      check($sformatf("step%0d change", i), change_amount, s.change);
      check($sformatf("step%0d error_count", i), err_seen - e0, s.err);
      if (s.vend) check($sformatf("step%0d vend_seen", i), sb.size(), 0);
    end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int e0;
    // key, price, qty, total, entered, change, err, vend, product, qty, change
    steps.push_back(mk(S,  0, 0,  0,  0,  0, 0));            // 0 exact payment
    steps.push_back(mk(0, 10, 0,  0,  0,  0, 0));
    steps.push_back(mk(2, 10, 2, 20,  0,  0, 0));
    steps.push_back(mk(K, 10, 2, 20,  0,  0, 0));
    steps.push_back(mk(3, 10, 2, 20, 10,  0, 0));
    steps.push_back(mk(3, 10, 2, 20, 20,  0, 0, 1, 0, 2, 0));
    steps.push_back(mk(S,  0, 0,  0,  0,  0, 0));            // 6 stock[0] now 1
    steps.push_back(mk(0, 10, 0,  0,  0,  0, 0));
    steps.push_back(mk(2, 10, 0,  0,  0,  0, 1));
    steps.push_back(mk(1, 10, 1, 10,  0,  0, 0));
    steps.push_back(mk(X,  0, 0,  0,  0,  0, 0));
    steps.push_back(mk(S,  0, 0,  0,  0,  0, 0));            // 11 overpay
    steps.push_back(mk(2, 20, 0,  0,  0,  0, 0));
    steps.push_back(mk(1, 20, 1, 20,  0,  0, 0));
    steps.push_back(mk(K, 20, 1, 20,  0,  0, 0));
    steps.push_back(mk(3, 20, 1, 20, 10,  0, 0));
    steps.push_back(mk(3, 20, 1, 20, 20,  0, 0, 1, 2, 1, 0));
    steps.push_back(mk(2, 20, 1, 20, 20,  0, 0));            // late coin ignored in IDLE
    steps.push_back(mk(S,  0, 0,  0,  0,  0, 0));
    steps.push_back(mk(3, 25, 0,  0,  0,  0, 0));
    steps.push_back(mk(1, 25, 1, 25,  0,  0, 0));
    steps.push_back(mk(K, 25, 1, 25,  0,  0, 0));
    steps.push_back(mk(3, 25, 1, 25, 10,  0, 0));
    steps.push_back(mk(3, 25, 1, 25, 20,  0, 0));
    steps.push_back(mk(3, 25, 1, 25, 30,  5, 0, 1, 3, 1, 5));
    steps.push_back(mk(S,  0, 0,  0,  0,  5, 0));            // 25 stock exhaustion
    steps.push_back(mk(1, 15, 0,  0,  0,  5, 0));
    steps.push_back(mk(3, 15, 3, 45,  0,  5, 0));
    steps.push_back(mk(K, 15, 3, 45,  0,  5, 0));
    steps.push_back(mk(3, 15, 3, 45, 10,  5, 0));
    steps.push_back(mk(3, 15, 3, 45, 20,  5, 0));
    steps.push_back(mk(3, 15, 3, 45, 30,  5, 0));
    steps.push_back(mk(3, 15, 3, 45, 40,  5, 0));
    steps.push_back(mk(2, 15, 3, 45, 45,  0, 0, 1, 1, 3, 0));
    steps.push_back(mk(S,  0, 0,  0,  0,  0, 0));
    steps.push_back(mk(1,  0, 0,  0,  0,  0, 1));
    steps.push_back(mk(0, 10, 0,  0,  0,  0, 0));
    steps.push_back(mk(X,  0, 0,  0,  0,  0, 0));
    steps.push_back(mk(S,  0, 0,  0,  0,  0, 0));            // 38 cancel/refund
    steps.push_back(mk(3, 25, 0,  0,  0,  0, 0));
    steps.push_back(mk(1, 25, 1, 25,  0,  0, 0));
    steps.push_back(mk(K, 25, 1, 25,  0,  0, 0));
    steps.push_back(mk(3, 25, 1, 25, 10,  0, 0));
    steps.push_back(mk(2, 25, 1, 25, 15,  0, 0));
    steps.push_back(mk(X,  0, 0,  0,  0, 15, 0));
    steps.push_back(mk(S,  0, 0,  0,  0, 15, 0));            // 45 stock[3] still 2
    steps.push_back(mk(3, 25, 0,  0,  0, 15, 0));
    steps.push_back(mk(2, 25, 2, 50,  0, 15, 0));
    steps.push_back(mk(3, 25, 2, 50,  0, 15, 1));
    steps.push_back(mk(K, 25, 2, 50,  0, 15, 0));
    steps.push_back(mk(2, 25, 2, 50,  5, 15, 0));
    steps.push_back(mk(1, 25, 2, 50,  7, 15, 0));
    steps.push_back(mk(S,  0, 0,  0,  0,  7, 0));            // 52 into PAY for held keys
    steps.push_back(mk(3, 25, 0,  0,  0,  7, 0));
    steps.push_back(mk(1, 25, 1, 25,  0,  7, 0));
    steps.push_back(mk(K, 25, 1, 25,  0,  7, 0));
    steps.push_back(mk(S,  0, 0,  0,  0,  0, 0));            // 56 after reset
    steps.push_back(mk(0, 10, 0,  0,  0,  0, 0));
    steps.push_back(mk(4, 10, 0,  0,  0,  0, 1));
    steps.push_back(mk(3, 10, 3, 30,  0,  0, 0));
    steps.push_back(mk(K, 10, 3, 30,  0,  0, 0));
    steps.push_back(mk(3, 10, 3, 30, 10,  0, 0));
    steps.push_back(mk(3, 10, 3, 30, 20,  0, 0));
    steps.push_back(mk(3, 10, 3, 30, 30,  0, 0, 1, 0, 3, 0));

    reset = 1'b0;
    release_keys();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    run_steps(0, 51);

    repeat (40) @(posedge clk);
    @(negedge clk);
    check("timeout_early entered", entered_amount, 7);
    check("timeout_early change", change_amount, 15);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("timeout change", change_amount, 7);
    check("timeout entered", entered_amount, 0);
    check("timeout view_price_q", view_price_q, 0);

    run_steps(52, 55);

    e0 = err_seen;
    @(posedge clk); #1 drive_key(4'd2);
    repeat (20) @(posedge clk);
    #1 begin c = 4'b1110; r = 4'b1100; end
    repeat (3) @(posedge clk);
    #1 drive_key(4'd2);
    repeat (3) @(posedge clk);
    #1 release_keys();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("held_coin entered", entered_amount, 5);
    @(posedge clk); #1 begin c = 4'b1100; r = 4'b1110; end
    repeat (3) @(posedge clk);
    #1 release_keys();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("two_key entered", entered_amount, 5);
    check("two_key error_count", err_seen - e0, 0);
    press_key(4'd3);
    check("coin_after_two_key entered", entered_amount, 15);

    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_pay");

    run_steps(56, 63);

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Parametrised vending-machine controller, successor to the fixed four-product `finite_state` FSM. It decodes the active-low 4x4 keypad (`c` columns, `r` rows) into single key-press events. It then runs the purchase flow: start, select product, select quantity, pay, vend and change. New over the previous generation: per-product stock counters, coin accumulation with change, cancel/refund, inactivity timeout, and generic product count, price width and quantity limit.

## Interface
- `NUM_PRODUCTS`, 4: number of products, 1..12; product keys are 0..NUM_PRODUCTS-1.
- `PRICE_W`, 8: width of all money values.
- `PRICES`, {8'd25,8'd20,8'd15,8'd10}: flattened NUM_PRODUCTS*PRICE_W unit prices; product 0 is in the LSBs.
- `MAX_QTY`, 4: largest selectable quantity, 1..9.
- `INIT_STOCK`, 3: stock loaded into every product counter at reset.
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed in SELECT, QTY or PAY.
- `clk` in 1: clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `c` in 4: keypad columns, active-low.
- `r` in 4: keypad rows, active-low.
- `view_price` out PRICE_W: unit price of the selected product.
- `view_quantity` out 8: selected quantity.
- `view_price_q` out PRICE_W: total price.
- `entered_amount` out PRICE_W: coins accepted so far.
- `change_amount` out PRICE_W: change or refund from the last transaction.
- `vend_valid` out 1: one-cycle dispense strobe.
- `vend_product` out 4: product being dispensed.
- `vend_qty` out 8: quantity being dispensed.
- `error` out 1: one-cycle pulse on a rejected key.

## Operation
- **Key decode**
  - A key is valid only if exactly one bit of `c` is 0 and exactly one bit of `r` is 0. Key = 4*row_idx + col_idx.
  - A press event is generated only on the transition from all-ones (released) to a valid key. Holding a key produces one event.
  - Invalid or multi-key patterns are ignored and do not re-arm the press detector.
- **Key map**: 15 = START, 14 = CONFIRM, 13 = CANCEL.
  - In PAY, keys 0/1/2/3 are coins worth 1/2/5/10.
- **IDLE**
  - START: clear the view outputs and `entered_amount`, keep `change_amount`, go to SELECT. Other keys are ignored.
- **SELECT**
  - Key k < NUM_PRODUCTS with stock[k] > 0: latch k, set `view_price` = PRICES[k], go to QTY.
  - Key k with stock 0, or any other key: pulse `error`, stay.
- **QTY**
  - Key q with 1 ≤ q ≤ MAX_QTY: set `view_quantity` = q and `view_price_q` = price*q. Reselection is allowed.
  - Reject with `error` if q > stock or if price*q ≥ 2^PRICE_W.
  - CONFIRM with quantity ≠ 0: go to PAY. CONFIRM with quantity = 0: pulse `error`.
- **PAY**
  - A coin adds its value to `entered_amount`. A coin that would overflow PRICE_W is rejected with `error`.
  - When `entered_amount` ≥ `view_price_q`, go to VEND.
- **VEND** (one cycle)
  - Pulse `vend_valid` with `vend_product` and `vend_qty`.
  - stock -= qty.
  - `change_amount` = entered − total.
  - Go to IDLE.
- **CANCEL** in SELECT, QTY or PAY: `change_amount` = `entered_amount`, clear the views, go to IDLE. No vend, no stock change.
- **Timeout**: an inactivity counter runs in SELECT, QTY and PAY. It resets on every press event. On reaching TIMEOUT_CYCLES it behaves exactly as CANCEL.
- **Stock**: counters never underflow; the quantity checks guarantee this.

## Timing
- **Input sampling**: `c`/`r` are registered once. A press is decoded from the registered value. State and outputs update on the next edge, so there are 2 clock edges from pattern applied to output visible.
- **Outputs**: all registered.
  - `vend_valid` and `error` are high for exactly 1 cycle.
  - VEND is entered on the edge after the coin that completes payment, so `vend_valid` appears 3 edges after that coin's pattern.
- **Reset** (`reset`=0 at an edge), from any state including mid-PAY:
  - state IDLE, all outputs 0;
  - all stock counters = INIT_STOCK;
  - press detector re-armed (treated as released);
  - timeout counter 0;
  - no refund is reported.
- **Simultaneous events**: a press on the same edge as timeout expiry is discarded; timeout wins.

## Structure
- `vend_pkg` holds:
  - the state enum (IDLE, SELECT, QTY, PAY, VEND);
  - key-code constants (START/CONFIRM/CANCEL);
  - the coin value table;
  - a `key_valid` helper function.
- Sub-module `keypad_decoder`: input register, one-hot validity check, key index and single-shot press event.
- The top level holds the FSM, the money datapath, the stock array and the timeout counter.

## Test plan
- **Buy, exact payment**: reset, START, key 0, key 2, CONFIRM → `view_price`=10, `view_quantity`=2, `view_price_q`=20. Coin 10 twice → `entered_amount`=20, `vend_valid` pulse with product 0 qty 2, `change_amount`=0, stock[0]=1.
- **Overpay**: product 2 qty 1 (total 20), coins 10,10,5 → vend after the second 10 with change 0. Product 3 qty 1 (total 25), coins 10,10,10 → `change_amount`=5.
- **Stock exhaustion**:
  - qty 3 of product 1 → vend, stock 0;
  - then START + key 1 → `error` pulse, stays in SELECT;
  - qty 4 on product 0 at stock 3 → `error`.
- **Cancel/refund**: PAY with `entered_amount`=15, CANCEL → `change_amount`=15, IDLE, no `vend_valid`, stock unchanged.
- **Timeout and held keys**:
  - TIMEOUT_CYCLES=50, idle in PAY after 7 entered → refund 7 at cycle 50, IDLE.
  - Coin key held for 20 cycles counts once.
  - Two-key pattern → ignored.
- **Reset mid-PAY**: `reset`=0 for 1 cycle → all outputs 0, stock back to 3, next START works normally.
